// File: rtl/irrigation_mode_ctrl.sv
// irrigation_mode_ctrl
//   Irrigation mode controller. It produces the AS/GT/US mode code that the
//   7-segment watering-mode display shows. Each asynchronous sensor goes
//   through a 2-flop synchronizer and a per-sensor debounce counter before it
//   reaches the mode FSM. The FSM enforces a minimum dwell time in each
//   watering/saturated state.
//
//   Optional feature macro: WATER_TIMEOUT_EN
//     When defined, a watering counter forces FAULT after MAX_WATER
//     consecutive cycles spent in SPRINKLE/DRIP.
//
// Ports
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   en       : irrigation enable (synchronous)
//   hum_low  : soil dry sensor (asynchronous)
//   hum_high : soil wet sensor (asynchronous)
//   tank_low : reservoir empty sensor (asynchronous)
//   ack      : operator fault acknowledge pulse (synchronous)
//   AS       : sprinkler active
//   GT       : drip active
//   US       : saturated / stop indicator
//   fault    : high while in FAULT
module irrigation_mode_ctrl #(
  parameter int unsigned DEBOUNCE  = 4,
  parameter int unsigned MIN_DWELL = 8,
  parameter int unsigned MAX_WATER = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic hum_low,
  input  logic hum_high,
  input  logic tank_low,
  input  logic ack,
  output logic AS,
  output logic GT,
  output logic US,
  output logic fault
);

  localparam int unsigned DBW = $clog2(DEBOUNCE + 1);
  localparam int unsigned DWW = $clog2(MIN_DWELL + 1);

  // Encodings equal the (AS,GT,US) display code, so the outputs are
  // taken straight from the state flops.
  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    SPRINKLE  = 3'b100,
    DRIP      = 3'b010,
    SATURATED = 3'b001,
    FAULT     = 3'b011
  } state_t;

  // Sensor bit order: [0]=hum_low, [1]=hum_high, [2]=tank_low
  logic [2:0]     sync1;
  logic [2:0]     sync2;
  logic [2:0]     flag;
  logic [DBW-1:0] dbc [3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      flag  <= '0;
      for (int unsigned i = 0; i < 3; i++) dbc[i] <= '0;
    end else begin
      sync1 <= {tank_low, hum_high, hum_low};
      sync2 <= sync1;
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] == flag[i]) begin
          dbc[i] <= '0;
        end else if (dbc[i] == DBW'(DEBOUNCE - 1)) begin
          // This is the DEBOUNCE-th consecutive mismatching cycle.
          flag[i] <= sync2[i];
          dbc[i]  <= '0;
        end else begin
          dbc[i] <= dbc[i] + 1'b1;
        end
      end
    end
  end

  logic hum_low_d, hum_high_d, tank_low_d;
  assign hum_low_d  = flag[0];
  assign hum_high_d = flag[1];
  assign tank_low_d = flag[2];

  state_t         state, nxt;
  logic [DWW-1:0] dwell;
  logic           dwell_ok;
  logic           fault_q;

  assign dwell_ok = (dwell == DWW'(MIN_DWELL));

`ifdef WATER_TIMEOUT_EN
  localparam int unsigned WW = $clog2(MAX_WATER + 1);
  logic [WW-1:0] water;
  logic          water_to;

  assign water_to = (water == WW'(MAX_WATER));

  // The counter is held at zero outside SPRINKLE/DRIP. Entry from any
  // other state therefore starts from zero. A SPRINKLE<->DRIP swap keeps
  // the running count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      water <= '0;
    end else if (state == SPRINKLE || state == DRIP) begin
      if (!water_to) water <= water + 1'b1;
    end else begin
      water <= '0;
    end
  end
`else
  // MAX_WATER only matters when the timeout is built in.
  if (MAX_WATER == 0) begin : g_no_water_limit
  end
`endif

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (hum_high_d)                             nxt = SATURATED;
        else if (en && hum_low_d && !tank_low_d)    nxt = SPRINKLE;
        else if (en && !tank_low_d)                 nxt = DRIP;
      end
      SPRINKLE, DRIP: begin
        if (tank_low_d)                             nxt = FAULT;
        else if (hum_high_d)                        nxt = SATURATED;
        else if (!en)                               nxt = IDLE;
`ifdef WATER_TIMEOUT_EN
        else if (water_to)                          nxt = FAULT;
`endif
        else if (state == SPRINKLE && !hum_low_d && dwell_ok) nxt = DRIP;
        else if (state == DRIP && hum_low_d && dwell_ok)      nxt = SPRINKLE;
      end
      SATURATED: begin
        if (!hum_high_d && dwell_ok)                nxt = IDLE;
      end
      FAULT: begin
        if (ack && !tank_low_d)                     nxt = IDLE;
      end
      default:                                      nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dwell   <= '0;
      fault_q <= 1'b0;
    end else begin
      state   <= nxt;
      fault_q <= (nxt == FAULT);
      if (nxt != state)  dwell <= '0;
      else if (!dwell_ok) dwell <= dwell + 1'b1;
    end
  end

  assign AS    = state[2];
  assign GT    = state[1];
  assign US    = state[0];
  assign fault = fault_q;

endmodule

// File: tb/tb_irrigation_mode_ctrl.sv
// Self-checking bench for irrigation_mode_ctrl with the default parameters
// (DEBOUNCE=4, MIN_DWELL=8, MAX_WATER=64). Every observed value is the
// 4-bit vector {AS,GT,US,fault}.
module tb_irrigation_mode_ctrl;

  logic clk = 1'b0;
  logic rst_n, en, hum_low, hum_high, tank_low, ack;
  logic AS, GT, US, fault;

  irrigation_mode_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .hum_low  (hum_low),
    .hum_high (hum_high),
    .tank_low (tank_low),
    .ack      (ack),
    .AS       (AS),
    .GT       (GT),
    .US       (US),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] exp;
    string      tag;
  } sb_t;

  sb_t sb[$];
  sb_t e;
  int  n_vec  = 0;
  int  n_miss = 0;

  localparam logic [3:0] O_IDLE = 4'b0000;
  localparam logic [3:0] O_SPR  = 4'b1000;
  localparam logic [3:0] O_DRIP = 4'b0100;
  localparam logic [3:0] O_SAT  = 4'b0010;
  localparam logic [3:0] O_FLT  = 4'b0111;

  function automatic logic [3:0] obs();
    return {AS, GT, US, fault};
  endfunction

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; hum_low = 1'b0; hum_high = 1'b0;
    tank_low = 1'b0; ack = 1'b0;
    edges(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; hum_low = 1'b0; hum_high = 1'b0;
    tank_low = 1'b0; ack = 1'b0;
    sb.push_back('{O_IDLE, "reset_state"});
    edges(1);
    e = sb.pop_front(); n_vec++;
    if (obs() !== e.exp) begin n_miss++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.exp); end
    rst_n = 1'b1;
    sb.push_back('{O_IDLE, "idle_hold"});
    edges(10);
    e = sb.pop_front(); n_vec++;
    if (obs() !== e.exp) begin n_miss++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.exp); end
  endtask

  // Sensor-step latency: DRIP with dwell satisfied, hum_low rises and
  // SPRINKLE appears on the 7th edge. Then reset is asserted between edges.
  task automatic test_latency();
    do_reset();
    en = 1'b1;
    sb.push_back('{O_DRIP, "drip_entry"});
    edges(1);
    e = sb.pop_front(); n_vec++;
    if (obs() !== e.exp) begin n_miss++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.exp); end
    edges(10);
    hum_low = 1'b1;
    sb.push_back('{O_DRIP, "latency_edge6"});
    sb.push_back('{O_SPR,  "latency_edge7"});
    edges(6);
    e = sb.pop_front(); n_vec++;
    if (obs() !== e.exp) begin n_miss++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.exp); end
    edges(1);
    e = sb.pop_front(); n_vec++;
    if (obs() !== e.exp) begin n_miss++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.exp); end
    #2 rst_n = 1'b0;
    sb.push_back('{O_IDLE, "async_reset"});
    #1;
    e = sb.pop_front(); n_vec++;
    if (obs() !== e.exp) begin n_miss++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.exp); end
    en = 1'b0; hum_low = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // SPRINKLE, hum_low dropped at dwell cycle 2: leave only once dwell_ok.
  task automatic test_dwell();
    do_reset();
    hum_low = 1'b1;
    edges(8);
    en = 1'b1;
    sb.push_back('{O_SPR, "sprinkle_entry"});
    edges(1);
    e = sb.pop_front(); n_vec++;
    if (obs() !== e.exp) begin n_miss++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.exp); end
    edges(1);
    hum_low = 1'b0;
    sb.push_back('{O_SPR,  "dwell_edge7"});
    sb.push_back('{O_SPR,  "dwell_edge8"});
    sb.push_back('{O_DRIP, "dwell_to_drip"});
    edges(6);
    e = sb.pop_front(); n_vec++;
    if (obs() !== e.exp) begin n_miss++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.exp); end
    edges(1);
    e = sb.pop_front(); n_vec++;
    if (obs() !== e.exp) begin n_miss++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.exp); end
    edges(1);
    e = sb.pop_front(); n_vec++;
    if (obs() !== e.exp) begin n_miss++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.exp); end
    sb.push_back('{O_DRIP, "drip_hold"});
    edges(20);
    e = sb.pop_front(); n_vec++;
    if (obs() !== e.exp) begin n_miss++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.exp); end
  endtask

  // Short hum_low pulse while SATURATED must never be seen.
  task automatic test_glitch();
    do_reset();
    hum_high = 1'b1;
    sb.push_back('{O_IDLE, "sat_edge6"});
    sb.push_back('{O_SAT,  "sat_edge7"});
    edges(6);
    e = sb.pop_front(); n_vec++;
    if (obs() !== e.exp) begin n_miss++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.exp); end
    edges(1);
    e = sb.pop_front(); n_vec++;
    if (obs() !== e.exp) begin n_miss++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.exp); end
    en = 1'b1;
    hum_low = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == 3) hum_low = 1'b0;
      sb.push_back('{O_SAT, "glitch_hold"});
      edges(1);
      e = sb.pop_front(); n_vec++;
      if (obs() !== e.exp) begin n_miss++; $display("FAIL %s[%0d]: observed %b expected %b", e.tag, i, obs(), e.exp); end
    end
    hum_high = 1'b0;
    sb.push_back('{O_SAT,  "unsat_edge6"});
    sb.push_back('{O_IDLE, "unsat_idle"});
    sb.push_back('{O_DRIP, "unsat_drip"});
    edges(6);
    e = sb.pop_front(); n_vec++;
    if (obs() !== e.exp) begin n_miss++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.exp); end
    edges(1);
    e = sb.pop_front(); n_vec++;
    if (obs() !== e.exp) begin n_miss++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.exp); end
    edges(1);
    e = sb.pop_front(); n_vec++;
    if (obs() !== e.exp) begin n_miss++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.exp); end
  endtask

  // tank_low and hum_high together from DRIP: tank_low has priority.
  task automatic test_fault();
    do_reset();
    en = 1'b1;
    edges(11);
    tank_low = 1'b1; hum_high = 1'b1;
    sb.push_back('{O_DRIP, "fault_edge6"});
    sb.push_back('{O_FLT,  "fault_edge7"});
    edges(6);
    e = sb.pop_front(); n_vec++;
    if (obs() !== e.exp) begin n_miss++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.exp); end
    edges(1);
    e = sb.pop_front(); n_vec++;
    if (obs() !== e.exp) begin n_miss++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.exp); end
    ack = 1'b1;
    edges(1);
    ack = 1'b0;
    sb.push_back('{O_FLT, "ack_while_tank_low"});
    edges(1);
    e = sb.pop_front(); n_vec++;
    if (obs() !== e.exp) begin n_miss++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.exp); end
    tank_low = 1'b0;
    sb.push_back('{O_FLT, "fault_hold_no_ack"});
    edges(8);
    e = sb.pop_front(); n_vec++;
    if (obs() !== e.exp) begin n_miss++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.exp); end
    ack = 1'b1;
    sb.push_back('{O_IDLE, "fault_exit"});
    edges(1);
    e = sb.pop_front(); n_vec++;
    if (obs() !== e.exp) begin n_miss++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.exp); end
    ack = 1'b0;
    sb.push_back('{O_SAT, "idle_to_sat"});
    edges(1);
    e = sb.pop_front(); n_vec++;
    if (obs() !== e.exp) begin n_miss++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.exp); end
  endtask

  task automatic test_en_drop();
    do_reset();
    en = 1'b1;
    sb.push_back('{O_DRIP, "en_drip_entry"});
    edges(1);
    e = sb.pop_front(); n_vec++;
    if (obs() !== e.exp) begin n_miss++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.exp); end
    edges(3);
    en = 1'b0;
    sb.push_back('{O_IDLE, "en_drop"});
    edges(1);
    e = sb.pop_front(); n_vec++;
    if (obs() !== e.exp) begin n_miss++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.exp); end
    en = 1'b1;
    sb.push_back('{O_DRIP, "en_rise"});
    edges(1);
    e = sb.pop_front(); n_vec++;
    if (obs() !== e.exp) begin n_miss++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.exp); end
  endtask

  task automatic test_timeout();
    do_reset();
    hum_low = 1'b1;
    edges(8);
    en = 1'b1;
    sb.push_back('{O_SPR, "water_entry"});
    edges(1);
    e = sb.pop_front(); n_vec++;
    if (obs() !== e.exp) begin n_miss++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.exp); end
`ifdef WATER_TIMEOUT_EN
    sb.push_back('{O_SPR, "water_at_limit"});
    sb.push_back('{O_FLT, "water_timeout"});
    edges(64);
    e = sb.pop_front(); n_vec++;
    if (obs() !== e.exp) begin n_miss++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.exp); end
    edges(1);
    e = sb.pop_front(); n_vec++;
    if (obs() !== e.exp) begin n_miss++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.exp); end
`else
    sb.push_back('{O_SPR, "no_timeout"});
    edges(200);
    e = sb.pop_front(); n_vec++;
    if (obs() !== e.exp) begin n_miss++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.exp); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_latency();
    test_dwell();
    test_glitch();
    test_fault();
    test_en_drop();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
